// File: rtl/idct_stream_driver_if.sv
// Stream bundle between the IDCT driver and its downstream transform engine.
// The driver takes the master modport: it sources coefficient rows and sinks result rows.
interface idct_stream_driver_if;
    logic [95:0] master_tdata;
    logic        master_tvalid;
    logic        slave_tready;
    logic [71:0] slave_tdata;
    logic        slave_tvalid;
    logic        master_tready;

    modport master (
        output master_tdata,
        output master_tvalid,
        output master_tready,
        input  slave_tready,
        input  slave_tdata,
        input  slave_tvalid
    );

    modport slave (
        input  master_tdata,
        input  master_tvalid,
        input  master_tready,
        output slave_tready,
        output slave_tdata,
        output slave_tvalid
    );
endinterface

// File: rtl/idct_stream_driver.sv
// IDCT stream driver: buffers an 8x8 coefficient block, streams it out row by row,
// then collects eight 8x9-bit result rows into a readable result store.
// Optional feature macro: IDCT_DRV_TIMEOUT_EN enables a receive-phase idle timeout
// that raises the sticky error flag; without it error is tied low.
module idct_stream_driver #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 coef_we,
    input  logic [5:0]           coef_addr,
    input  logic [11:0]          coef_wdata,
    input  logic                 start,
    idct_stream_driver_if.master stream,
    input  logic [5:0]           res_addr,
    output logic [8:0]           res_rdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [1:0] {StIdle, StSend, StRecv} state_e;

    state_e      state_q;
    logic [2:0]  row_q;
    logic        tvalid_q;
    logic        tready_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic [11:0] coef_mem [64];
    logic [8:0]  res_mem  [64];
    logic [95:0] row_data;
    logic        out_fire;
    logic        in_fire;

`ifdef IDCT_DRV_TIMEOUT_EN
    logic [31:0] idle_q;
`else
    logic        unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    assign out_fire = tvalid_q & stream.slave_tready;
    assign in_fire  = tready_q & stream.slave_tvalid;

    // Coefficient loads are only honoured while idle so an in-flight block stays coherent.
    always_ff @(posedge clock) begin
        if (coef_we && state_q == StIdle) begin
            coef_mem[coef_addr] <= coef_wdata;
        end
    end

    // Each accepted inbound beat fills one result row; tready is only high in RECV.
    always_ff @(posedge clock) begin
        if (in_fire) begin
            for (int c = 0; c < 8; c++) begin
                res_mem[{row_q, 3'(c)}] <= stream.slave_tdata[9*c +: 9];
            end
        end
    end

    // Outbound row is a direct view of the store; it cannot change during SEND.
    always_comb begin
        row_data = '0;
        for (int c = 0; c < 8; c++) begin
            row_data[12*c +: 12] = coef_mem[{row_q, 3'(c)}];
        end
    end

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            row_q    <= 3'd0;
            tvalid_q <= 1'b0;
            tready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef IDCT_DRV_TIMEOUT_EN
            idle_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StSend;
                        row_q    <= 3'd0;
                        tvalid_q <= 1'b1;
                        busy_q   <= 1'b1;
                        error_q  <= 1'b0;
                    end
                end
                StSend: begin
                    if (out_fire) begin
                        if (row_q == 3'd7) begin
                            state_q  <= StRecv;
                            row_q    <= 3'd0;
                            tvalid_q <= 1'b0;
                            tready_q <= 1'b1;
`ifdef IDCT_DRV_TIMEOUT_EN
                            idle_q   <= '0;
`endif
                        end else begin
                            row_q <= row_q + 3'd1;
                        end
                    end
                end
                StRecv: begin
                    if (in_fire) begin
`ifdef IDCT_DRV_TIMEOUT_EN
                        idle_q <= '0;
`endif
                        if (row_q == 3'd7) begin
                            state_q  <= StIdle;
                            row_q    <= 3'd0;
                            tready_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            row_q <= row_q + 3'd1;
                        end
                    end
`ifdef IDCT_DRV_TIMEOUT_EN
                    else if (idle_q == TIMEOUT_CYCLES - 1) begin
                        state_q  <= StIdle;
                        row_q    <= 3'd0;
                        tready_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        error_q  <= 1'b1;
                        idle_q   <= '0;
                    end else begin
                        idle_q <= idle_q + 32'd1;
                    end
`endif
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign stream.master_tdata  = row_data;
    assign stream.master_tvalid = tvalid_q;
    assign stream.master_tready = tready_q;
    assign res_rdata            = res_mem[res_addr];
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign error                = error_q;

endmodule

// File: tb/tb_idct_stream_driver.sv
// Self-checking bench for idct_stream_driver: directed block runs with randomized data,
// checked against an array-based model of the coefficient and result stores.
// Timeout checks are built when IDCT_DRV_TIMEOUT_EN is defined.
module tb_idct_stream_driver;

`ifdef IDCT_DRV_TIMEOUT_EN
    localparam int unsigned TO = 16;
`else
    localparam int unsigned TO = 1024;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        coef_we = 1'b0;
    logic [5:0]  coef_addr = '0;
    logic [11:0] coef_wdata = '0;
    logic        start = 1'b0;
    logic [5:0]  res_addr = '0;
    logic [8:0]  res_rdata;
    logic        busy;
    logic        done;
    logic        error;

    idct_stream_driver_if stream ();

    idct_stream_driver #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_wdata(coef_wdata),
        .start     (start),
        .stream    (stream),
        .res_addr  (res_addr),
        .res_rdata (res_rdata),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [11:0] coef_model [64];
    logic [8:0]  res_model  [64];

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [95:0] pack_row(input int r);
        logic [95:0] v;
        for (int c = 0; c < 8; c++) v[12*c +: 12] = coef_model[r*8 + c];
        return v;
    endfunction

    task automatic write_coef(input int a, input logic [11:0] d);
        coef_we = 1'b1;
        coef_addr = 6'(a);
        coef_wdata = d;
        coef_model[a] = d;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic check_results(input string tag);
        for (int i = 0; i < 64; i++) begin
            res_addr = 6'(i);
            #1;
            check(tag, {87'd0, res_rdata}, {87'd0, res_model[i]});
        end
    endtask

    // Runs one block end to end. indexed: inbound element = row*8+col, else random.
    // stall: 5-cycle back-pressure on row 3 plus random inbound bubbles.
    // meddle: stray start / coef write / slave_tvalid during SEND, all to be ignored.
    task automatic run_block(input bit indexed, input bit stall, input bit meddle,
                             input bit cw_en, input int cw_addr, input logic [11:0] cw_data);
        int sent = 0;
        int rcvd = 0;
        int cyc;
        int idle = 0;
        int held = 0;
        bit rdy;
        bit v;
        logic [71:0] data;
        logic [8:0] elem;
        logic [8:0] pend [8];
        start = 1'b1;
        coef_we = cw_en;
        coef_addr = 6'(cw_addr);
        coef_wdata = cw_data;
        if (cw_en) coef_model[cw_addr] = cw_data;
        tick();
        start = 1'b0;
        coef_we = 1'b0;
        cyc = 1;
        while (sent < 8 && cyc < 200) begin
            check("send_tvalid", {95'd0, stream.master_tvalid}, 96'd1);
            check("send_busy", {95'd0, busy}, 96'd1);
            check("send_tready_low", {95'd0, stream.master_tready}, 96'd0);
            check("send_tdata", stream.master_tdata, pack_row(sent));
            if (meddle && cyc == 2) begin
                start = 1'b1;
                coef_we = 1'b1;
                coef_addr = 6'd63;
                coef_wdata = ~coef_model[63];
                stream.slave_tvalid = 1'b1;
                stream.slave_tdata = {8'd0, $urandom(), $urandom()};
            end
            rdy = 1'b1;
            if (stall && sent == 3 && held < 5) begin
                rdy = 1'b0;
                held++;
            end
            stream.slave_tready = rdy;
            if (rdy) sent++; else idle++;
            tick();
            cyc++;
            start = 1'b0;
            coef_we = 1'b0;
            stream.slave_tvalid = 1'b0;
        end
        stream.slave_tready = 1'b0;
        check("send_bound", 96'(sent), 96'd8);
        while (rcvd < 8 && cyc < 400) begin
            check("recv_tready", {95'd0, stream.master_tready}, 96'd1);
            check("recv_tvalid_low", {95'd0, stream.master_tvalid}, 96'd0);
            check("recv_done_low", {95'd0, done}, 96'd0);
            v = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            for (int c = 0; c < 8; c++) begin
                elem = indexed ? 9'(rcvd*8 + c) : 9'($urandom_range(0, 511));
                data[9*c +: 9] = elem;
                pend[c] = elem;
            end
            stream.slave_tvalid = v;
            stream.slave_tdata = data;
            if (v) begin
                for (int c = 0; c < 8; c++) res_model[rcvd*8 + c] = pend[c];
                rcvd++;
            end else begin
                idle++;
            end
            tick();
            cyc++;
        end
        stream.slave_tvalid = 1'b0;
        check("recv_bound", 96'(rcvd), 96'd8);
        check("done_pulse", {95'd0, done}, 96'd1);
        check("done_busy", {95'd0, busy}, 96'd0);
        check("done_tready", {95'd0, stream.master_tready}, 96'd0);
        check("done_error", {95'd0, error}, 96'd0);
        check("latency", 96'(cyc), 96'(17 + idle));
        for (int k = 0; k < 3; k++) begin
            tick();
            check("after_done", {94'd0, done, busy}, 96'd0);
        end
    endtask

    initial begin
        int n;
        stream.slave_tready = 1'b0;
        stream.slave_tvalid = 1'b0;
        stream.slave_tdata = '0;
        for (int i = 0; i < 64; i++) res_model[i] = 'x;
        tick();
        tick();
        check("rst_tvalid", {95'd0, stream.master_tvalid}, 96'd0);
        check("rst_tready", {95'd0, stream.master_tready}, 96'd0);
        check("rst_busy", {95'd0, busy}, 96'd0);
        check("rst_done", {95'd0, done}, 96'd0);
        check("rst_error", {95'd0, error}, 96'd0);
        reset = 1'b0;
        tick();

        // Identity coefficients, indexed results, no back-pressure.
        for (int i = 0; i < 64; i++) write_coef(i, 12'(i));
        check("row0_literal", pack_row(0), 96'h007006005004003002001000);
        run_block(1'b1, 1'b0, 1'b0, 1'b0, 0, 12'd0);
        res_addr = 6'd37;
        #1;
        check("res37", {87'd0, res_rdata}, 96'd37);
        check_results("res_identity");

        // Random coefficients and results, with back-pressure and inbound bubbles.
        for (int i = 0; i < 64; i++) write_coef(i, 12'($urandom_range(0, 4095)));
        run_block(1'b0, 1'b1, 1'b0, 1'b0, 0, 12'd0);
        check_results("res_random");

        // Coef write alongside start is kept; mid-block start/write/tvalid ignored.
        run_block(1'b0, 1'b0, 1'b1, 1'b1, 0, 12'hFFF);
        check_results("res_meddle");

        // slave_tvalid while idle must not touch the result store.
        for (int k = 0; k < 3; k++) begin
            stream.slave_tvalid = 1'b1;
            stream.slave_tdata = {8'd0, $urandom(), $urandom()};
            tick();
            check("idle_tready", {95'd0, stream.master_tready}, 96'd0);
        end
        stream.slave_tvalid = 1'b0;
        check_results("res_idle_ignore");

        // Reset while row 4 is on the bus, then a fresh block restarts from row 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        stream.slave_tready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        stream.slave_tready = 1'b0;
        check("row4_before_rst", stream.master_tdata, pack_row(4));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_tvalid", {95'd0, stream.master_tvalid}, 96'd0);
        check("midrst_busy", {95'd0, busy}, 96'd0);
        check("midrst_tready", {95'd0, stream.master_tready}, 96'd0);
        check("midrst_done", {95'd0, done}, 96'd0);
        tick();
        check_results("res_after_rst");
        run_block(1'b0, 1'b0, 1'b0, 1'b0, 0, 12'd0);
        check_results("res_after_restart");

        // Receive phase with no inbound data.
        start = 1'b1;
        tick();
        start = 1'b0;
        stream.slave_tready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        stream.slave_tready = 1'b0;
        check("starve_tready", {95'd0, stream.master_tready}, 96'd1);
`ifdef IDCT_DRV_TIMEOUT_EN
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("timeout_latency", 96'(n), 96'd16);
        check("timeout_error", {95'd0, error}, 96'd1);
        check("timeout_busy", {95'd0, busy}, 96'd0);
        tick();
        check("error_sticky", {95'd0, error}, 96'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("error_cleared", {95'd0, error}, 96'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`else
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            n++;
            check("wait_indef", {93'd0, done, busy, stream.master_tready}, 96'd3);
            check("wait_error", {95'd0, error}, 96'd0);
        end
        for (int r = 0; r < 8; r++) begin
            stream.slave_tvalid = 1'b1;
            for (int c = 0; c < 8; c++) begin
                res_model[r*8 + c] = 9'($urandom_range(0, 511));
                stream.slave_tdata[9*c +: 9] = res_model[r*8 + c];
            end
            tick();
        end
        stream.slave_tvalid = 1'b0;
        check("late_done", {95'd0, done}, 96'd1);
        check_results("res_late");
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
